// File: rtl/pci_target_controller.sv
`default_nettype none
// ============================================================================
// Module  : pci_target_controller
// Brief   : PCI-style memory target: decodes address phase, claims reads and
//           writes to NUM_DEV registers, serves single/burst data phases,
//           disconnects at the end of the window and performs turnaround.
// Rev     : 1.0  initial release
// ============================================================================
module pci_target_controller #(
  parameter int unsigned BASE_ADDR = 21,
  parameter int unsigned NUM_DEV   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        ctl_oe,
  output logic [1:0]  dev_sel,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_BUSY_WAIT = 3'd1;
  localparam logic [2:0] S_RTURN     = 3'd2;
  localparam logic [2:0] S_RDATA     = 3'd3;
  localparam logic [2:0] S_WDATA     = 3'd4;
  localparam logic [2:0] S_DISC      = 3'd5;
  localparam logic [2:0] S_TAR       = 3'd6;

  localparam logic [3:0]  CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WR = 4'b0111;
  localparam logic [31:0] ADDR_LO    = 32'(BASE_ADDR);
  localparam logic [31:0] ADDR_HI    = 32'(BASE_ADDR + NUM_DEV - 1);
  localparam logic [1:0]  NO_DEV     = 2'd3;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DEV - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] regs_q [NUM_DEV];
  logic [31:0] regs_d [NUM_DEV];

  logic        addr_hit;
  logic [1:0]  addr_idx;
  logic        in_data;
  logic        abort;
  logic        xfer;
  logic [2:0]  next_idx;
  logic        next_in_range;

  // The window holds at most three devices, so the low two bits of the
  // difference are the full device index whenever the address hits.
  assign addr_hit      = (ad_in >= ADDR_LO) && (ad_in <= ADDR_HI);
  assign addr_idx      = ad_in[1:0] - ADDR_LO[1:0];
  assign in_data       = (state_q == S_RDATA) || (state_q == S_WDATA);
  assign abort         = frame_n && irdy_n;
  assign xfer          = in_data && !irdy_n;
  assign next_idx      = {1'b0, idx_q} + 3'd1;
  assign next_in_range = (next_idx <= LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      for (int d = 0; d < NUM_DEV; d++) begin
        regs_q[d] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int d = 0; d < NUM_DEV; d++) begin
        regs_q[d] <= regs_d[d];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (!frame_n) begin
          if (addr_hit && (cbe_n == CMD_MEM_WR)) begin
            state_d = S_WDATA;
            idx_d   = addr_idx;
          end else if (addr_hit && (cbe_n == CMD_MEM_RD)) begin
            state_d = S_RTURN;
            idx_d   = addr_idx;
          end else begin
            state_d = S_BUSY_WAIT;
          end
        end
      end
      S_BUSY_WAIT: begin
        if (frame_n && irdy_n) begin
          state_d = S_IDLE;
        end
      end
      S_RTURN: begin
        state_d = abort ? S_TAR : S_RDATA;
      end
      S_RDATA, S_WDATA: begin
        if (abort) begin
          state_d = S_TAR;
        end else if (xfer) begin
          if (frame_n) begin
            state_d = S_TAR;
          end else if (next_in_range) begin
            idx_d = next_idx[1:0];
          end else begin
            state_d = S_DISC;
          end
        end
      end
      S_DISC: begin
        if (frame_n) begin
          state_d = S_TAR;
        end
      end
      S_TAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register bank update with per-lane byte enables
  always_comb begin
    for (int d = 0; d < NUM_DEV; d++) begin
      regs_d[d] = regs_q[d];
    end
    if (xfer && (state_q == S_WDATA)) begin
      for (int k = 0; k < 4; k++) begin
        if (!cbe_n[k]) begin
          regs_d[idx_q][8*k +: 8] = ad_in[8*k +: 8];
        end
      end
    end
  end

  // Output logic
  always_comb begin
    ad_out   = 32'd0;
    ad_oe    = 1'b0;
    devsel_n = 1'b1;
    trdy_n   = 1'b1;
    stop_n   = 1'b1;
    ctl_oe   = 1'b0;
    dev_sel  = NO_DEV;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_RTURN: begin
        ctl_oe   = 1'b1;
        devsel_n = 1'b0;
        dev_sel  = idx_q;
      end
      S_RDATA: begin
        ctl_oe   = 1'b1;
        devsel_n = 1'b0;
        trdy_n   = 1'b0;
        ad_oe    = 1'b1;
        ad_out   = regs_q[idx_q];
        dev_sel  = idx_q;
      end
      S_WDATA: begin
        ctl_oe   = 1'b1;
        devsel_n = 1'b0;
        trdy_n   = 1'b0;
        dev_sel  = idx_q;
      end
      S_DISC: begin
        ctl_oe   = 1'b1;
        devsel_n = 1'b0;
        stop_n   = 1'b0;
        dev_sel  = idx_q;
      end
      S_TAR: begin
        ctl_oe   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pci_target_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_pci_target_controller
// Brief   : Directed self-checking bench for pci_target_controller.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pci_target_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        devsel_n;
  logic        trdy_n;
  logic        stop_n;
  logic        ctl_oe;
  logic [1:0]  dev_sel;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  pci_target_controller #(.BASE_ADDR(21), .NUM_DEV(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .cbe_n    (cbe_n),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .stop_n   (stop_n),
    .ctl_oe   (ctl_oe),
    .dev_sel  (dev_sel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cbe_n   = 4'h0;
    ad_in   = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
    frame_n = 1'b0;
    irdy_n  = 1'b1;
    ad_in   = addr;
    cbe_n   = cmd;
    tick();
  endtask

  task automatic write_single(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be_n,
                              input logic [1:0] exp_sel);
    addr_phase(addr, 4'b0111);
    chk({tag, ".devsel"}, devsel_n, 1'b0);
    chk({tag, ".trdy"}, trdy_n, 1'b0);
    chk({tag, ".dev_sel"}, dev_sel, exp_sel);
    frame_n = 1'b1;
    irdy_n  = 1'b0;
    ad_in   = data;
    cbe_n   = be_n;
    tick();
    chk({tag, ".tar_devsel"}, devsel_n, 1'b1);
    chk({tag, ".tar_ctl_oe"}, ctl_oe, 1'b1);
    bus_idle();
    tick();
    chk({tag, ".idle_ctl_oe"}, ctl_oe, 1'b0);
  endtask

  task automatic read_single(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data);
    addr_phase(addr, 4'b0110);
    chk({tag, ".rturn_ad_oe"}, ad_oe, 1'b0);
    chk({tag, ".rturn_devsel"}, devsel_n, 1'b0);
    chk({tag, ".rturn_trdy"}, trdy_n, 1'b1);
    frame_n = 1'b1;
    irdy_n  = 1'b0;
    ad_in   = 32'h0;
    cbe_n   = 4'h0;
    tick();
    chk({tag, ".data"}, ad_out, exp_data);
    chk({tag, ".ad_oe"}, ad_oe, 1'b1);
    chk({tag, ".trdy"}, trdy_n, 1'b0);
    tick();
    chk({tag, ".tar_ad_oe"}, ad_oe, 1'b0);
    chk({tag, ".tar_devsel"}, devsel_n, 1'b1);
    bus_idle();
    tick();
    chk({tag, ".idle_busy"}, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ad_out"}, ad_out, 32'h0);
    chk({tag, ".ad_oe"}, ad_oe, 1'b0);
    chk({tag, ".devsel"}, devsel_n, 1'b1);
    chk({tag, ".trdy"}, trdy_n, 1'b1);
    chk({tag, ".stop"}, stop_n, 1'b1);
    chk({tag, ".ctl_oe"}, ctl_oe, 1'b0);
    chk({tag, ".dev_sel"}, dev_sel, 2'd3);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  logic [31:0] unc_addr [4] = '{32'd26, 32'd24, 32'd20, 32'd22};
  logic [3:0]  unc_cmd  [4] = '{4'b0111, 4'b0111, 4'b0111, 4'b0010};

  initial begin
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    write_single("wr1", 32'd22, 32'hDEADBEEF, 4'b0000, 2'd1);
    read_single("rd1", 32'd22, 32'hDEADBEEF);

    write_single("wr_be", 32'd21, 32'h11223344, 4'b1010, 2'd0);
    read_single("rd_be", 32'd21, 32'h00220044);

    // Burst write running off the end of the window
    addr_phase(32'd22, 4'b0111);
    chk("bw.dev_sel0", dev_sel, 2'd1);
    irdy_n = 1'b0;
    ad_in  = 32'hA;
    cbe_n  = 4'h0;
    tick();
    chk("bw.dev_sel1", dev_sel, 2'd2);
    chk("bw.trdy1", trdy_n, 1'b0);
    ad_in = 32'hB;
    tick();
    chk("bw.disc_stop", stop_n, 1'b0);
    chk("bw.disc_trdy", trdy_n, 1'b1);
    chk("bw.disc_devsel", devsel_n, 1'b0);
    irdy_n = 1'b1;
    tick();
    chk("bw.disc_hold", stop_n, 1'b0);
    frame_n = 1'b1;
    irdy_n  = 1'b0;
    tick();
    chk("bw.tar_stop", stop_n, 1'b1);
    chk("bw.tar_ctl_oe", ctl_oe, 1'b1);
    bus_idle();
    tick();
    chk("bw.idle_busy", busy, 1'b0);

    // Burst read of registers 1 and 2
    addr_phase(32'd22, 4'b0110);
    irdy_n = 1'b0;
    cbe_n  = 4'h0;
    ad_in  = 32'h0;
    tick();
    chk("br.data0", ad_out, 32'hA);
    tick();
    chk("br.data1", ad_out, 32'hB);
    chk("br.dev_sel1", dev_sel, 2'd2);
    frame_n = 1'b1;
    tick();
    chk("br.tar_ad_oe", ad_oe, 1'b0);
    bus_idle();
    tick();

    // Unclaimed addresses and commands
    for (int i = 0; i < 4; i++) begin
      addr_phase(unc_addr[i], unc_cmd[i]);
      chk($sformatf("unc%0d.devsel", i), devsel_n, 1'b1);
      chk($sformatf("unc%0d.ctl_oe", i), ctl_oe, 1'b0);
      chk($sformatf("unc%0d.busy", i), busy, 1'b1);
      chk($sformatf("unc%0d.dev_sel", i), dev_sel, 2'd3);
      frame_n = 1'b1;
      irdy_n  = 1'b0;
      ad_in   = 32'hFFFFFFFF;
      cbe_n   = 4'h0;
      tick();
      chk($sformatf("unc%0d.wait", i), busy, 1'b1);
      bus_idle();
      tick();
      chk($sformatf("unc%0d.idle", i), busy, 1'b0);
    end
    read_single("unc.rd1", 32'd22, 32'hA);
    read_single("unc.rd2", 32'd23, 32'hB);

    // Reset in the middle of a read burst
    addr_phase(32'd21, 4'b0110);
    irdy_n = 1'b0;
    cbe_n  = 4'h0;
    ad_in  = 32'h0;
    tick();
    chk("rst.pre_data", ad_out, 32'h00220044);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    bus_idle();
    tick();
    read_single("rst.rd23", 32'd23, 32'h0);
    read_single("rst.rd21", 32'd21, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pci_target_controller.md
Name: pci_target_controller

Overview:
- PCI-style target sequencer wrapping the slave address decode (BASE_ADDR..BASE_ADDR+NUM_DEV-1 map to device 0..NUM_DEV-1; all other addresses map to "no device", code 3).
- Latches the address phase, claims matching transactions and drives devsel_n/trdy_n/stop_n.
- Serves single and burst memory reads/writes to one 32-bit register per device, then performs turnaround.
- Sits between the bus pins and the slave register bank.

Parameters:
- BASE_ADDR, 21, first decoded address (device 0).
- NUM_DEV, 3, number of claimed addresses/registers (1..3).

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_n  in  1  FRAME#, active-low.
- irdy_n  in  1  IRDY#, active-low.
- cbe_n  in  4  command (address phase) / byte enables, active-low (data phase).
- ad_in  in  32  AD bus as sampled.
- ad_out  out  32  read data to AD bus.
- ad_oe  out  1  AD output enable.
- devsel_n  out  1  DEVSEL#, active-low.
- trdy_n  out  1  TRDY#, active-low.
- stop_n  out  1  STOP#, active-low.
- ctl_oe  out  1  output enable for devsel_n/trdy_n/stop_n.
- dev_sel  out  2  decoded device index of the current phase; 3 = none.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst high at an edge, in any state, including mid-transaction):
  - state = IDLE; all registers = 0.
  - ad_out = 0, ad_oe = 0, devsel_n = 1, trdy_n = 1, stop_n = 1, ctl_oe = 0, dev_sel = 3, busy = 0.
- Commands: 4'b0110 = memory read, 4'b0111 = memory write; all other commands are not claimed.
- Decode: dev_sel = addr - BASE_ADDR if BASE_ADDR <= addr <= BASE_ADDR+NUM_DEV-1, else 3. Comparison is 32-bit unsigned.
- IDLE:
  - On an edge with frame_n = 0: latch addr = ad_in and cmd = cbe_n.
  - Claimed (in range and read/write): write -> WDATA; read -> RTURN.
  - Otherwise -> BUSY_WAIT.
- BUSY_WAIT: no outputs driven; return to IDLE on the first edge with frame_n = 1 and irdy_n = 1.
- RTURN (one cycle): ctl_oe = 1, devsel_n = 0, trdy_n = 1, ad_oe = 0 (AD turnaround) -> RDATA.
- RDATA: ad_oe = 1, ad_out = reg[idx], devsel_n = 0, trdy_n = 0.
- WDATA: devsel_n = 0, trdy_n = 0; ad_oe = 0.
- Data transfer occurs on an edge where irdy_n = 0 and trdy_n = 0 (zero target wait states).
  - Write: reg[idx] byte lane k is updated from ad_in only if cbe_n[k] = 0.
  - Read: data was already on ad_out during the cycle.
- After a transfer:
  - frame_n = 1 (last phase) -> TAR.
  - Else idx+1; if still in range, stay in the data state with ad_out updated next cycle.
  - If idx+1 is out of range -> DISC.
- DISC:
  - devsel_n = 0, trdy_n = 1, stop_n = 0, ad_oe = 0.
  - Held while frame_n = 0; on the first edge with frame_n = 1 -> TAR.
- Master abort: in RTURN/RDATA/WDATA, an edge with frame_n = 1 and irdy_n = 1 -> TAR, with no transfer.
- TAR (one cycle): ctl_oe = 1, devsel_n = trdy_n = stop_n = 1, ad_oe = 0 -> IDLE (ctl_oe = 0).
- A new frame_n = 0 seen in TAR is ignored; the bus protocol guarantees an idle cycle.
- dev_sel holds the current idx in the active states and is 3 in IDLE, BUSY_WAIT and TAR.
- Latency: devsel_n asserts exactly one cycle after the address-phase edge (fast decode).

Test Plan:
- Single write: addr = 22, cmd 0111, data 0xDEADBEEF, cbe_n = 0000, frame_n high in the data phase → devsel_n = 0 next cycle, reg1 = 0xDEADBEEF, TAR, then IDLE.
- Single read: addr = 22 after the test above → RTURN cycle with ad_oe = 0, then ad_out = 0xDEADBEEF, ad_oe = 1, trdy_n = 0; TAR follows.
- Byte-enable write: write 0x11223344 with cbe_n = 1010 to addr 21 (reg0 = 0) → reg0 = 0x00220044.
- Burst write with disconnect:
  - Stimulus: start at addr 22, data 0xA, 0xB, frame_n held low.
  - Expected: reg1 = 0xA, reg2 = 0xB.
  - Then stop_n = 0 with trdy_n = 1 until frame_n is released; TAR, then IDLE.
- Unclaimed: addr 26, 24 and 20 with cmd 0111, plus addr 22 with cmd 0010 → devsel_n stays 1, ctl_oe = 0, registers unchanged, BUSY_WAIT until frame_n = irdy_n = 1.
- Reset mid-burst: rst = 1 during RDATA → next cycle all outputs at reset values, regs = 0, dev_sel = 3; a following read of 23 returns 0.
